// File: rtl/banked_dp_ram_pkg.sv
// Shared types and constants for the banked dual-port RAM: clear-FSM state
// encoding, collision-counter width/saturation value and the lane-slice helper.
package banked_dp_ram_pkg;

  typedef logic [1:0] clr_state_t;
  localparam clr_state_t IDLE  = 2'd0;
  localparam clr_state_t CLEAR = 2'd1;
  localparam clr_state_t READY = 2'd2;

  localparam int COLL_CNT_W = 16;
  localparam logic [COLL_CNT_W-1:0] COLL_CNT_MAX = '1;

  // Low bit of lane 'lane' inside a packed word of DWIDTH-bit lanes
  function automatic int lane_lsb(input int lane, input int dwidth);
    return lane * dwidth;
  endfunction

endpackage

// File: rtl/bdr_read_pipe.sv
// Per-port read pipeline: optional write-first bypass merge, then one or two
// register stages for data and valid. Data holds whenever valid is low.
module bdr_read_pipe
  import banked_dp_ram_pkg::*;
#(
  parameter int DWIDTH       = 8,
  parameter int LANES        = 4,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    rd_en,
  input  logic [LANES*DWIDTH-1:0] arr_q,
  input  logic [LANES-1:0]        byp_mask,
  input  logic [LANES*DWIDTH-1:0] byp_d,
  output logic [LANES*DWIDTH-1:0] q,
  output logic                    q_valid
);

  logic [LANES*DWIDTH-1:0] merged;
  logic [LANES*DWIDTH-1:0] s1_q;
  logic                    s1_v;

  // Lanes being written this cycle at our address take the resolved new data
  always_comb begin
    merged = arr_q;
    for (int i = 0; i < LANES; i++) begin
      if ((WRITE_FIRST != 0) && byp_mask[i])
        merged[lane_lsb(i, DWIDTH) +: DWIDTH] = byp_d[lane_lsb(i, DWIDTH) +: DWIDTH];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_q <= '0;
      s1_v <= 1'b0;
    end else begin
      s1_v <= rd_en;
      if (rd_en) s1_q <= merged;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [LANES*DWIDTH-1:0] s2_q;
      logic                    s2_v;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          s2_q <= '0;
          s2_v <= 1'b0;
        end else begin
          s2_v <= s1_v;
          if (s1_v) s2_q <= s1_q;
        end
      end

      assign q       = s2_q;
      assign q_valid = s2_v;
    end else begin : g_lat1
      assign q       = s1_q;
      assign q_valid = s1_v;
    end
  endgenerate

endmodule

// File: rtl/banked_dp_ram.sv
// True dual-port lane-masked word RAM with A-priority collision resolve and a
// saturating collision counter. Define BANKED_DP_RAM_INIT_CLEAR_EN for the post-reset clear sweep.
module banked_dp_ram
  import banked_dp_ram_pkg::*;
#(
  parameter int DWIDTH       = 8,
  parameter int LANES        = 4,
  parameter int AWIDTH       = 10,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [AWIDTH-1:0]       a_addr,
  input  logic                    a_rd_en,
  input  logic [LANES-1:0]        a_we,
  input  logic [LANES*DWIDTH-1:0] a_d,
  output logic [LANES*DWIDTH-1:0] a_q,
  output logic                    a_q_valid,
  input  logic [AWIDTH-1:0]       b_addr,
  input  logic                    b_rd_en,
  input  logic [LANES-1:0]        b_we,
  input  logic [LANES*DWIDTH-1:0] b_d,
  output logic [LANES*DWIDTH-1:0] b_q,
  output logic                    b_q_valid,
  output logic [COLL_CNT_W-1:0]   coll_count,
  output logic                    busy
);

  localparam int W     = LANES * DWIDTH;
  localparam int DEPTH = 1 << AWIDTH;

  logic [W-1:0]     mem [DEPTH];
  logic [LANES-1:0] a_we_eff, b_we_eff, coll_lanes, b_we_res;
  logic [LANES-1:0] a_byp_mask, b_byp_mask;
  logic [W-1:0]     a_byp_d, b_byp_d;
  logic             same_addr, collision;

`ifdef BANKED_DP_RAM_INIT_CLEAR_EN
  clr_state_t        state;
  logic [AWIDTH-1:0] clr_addr;

  // Sweep every word to zero once after reset; user traffic is locked out until READY
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      clr_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= CLEAR;
          clr_addr <= '0;
        end
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == {AWIDTH{1'b1}}) state <= READY;
        end
        default: state <= READY;
      endcase
    end
  end

  assign busy = (state != READY);
`else
  assign busy = 1'b0;
`endif

  assign a_we_eff   = busy ? '0 : a_we;
  assign b_we_eff   = busy ? '0 : b_we;
  assign same_addr  = (a_addr == b_addr);
  assign coll_lanes = a_we_eff & b_we_eff & {LANES{same_addr}};
  assign b_we_res   = b_we_eff & ~coll_lanes;
  assign collision  = |coll_lanes;

  // Collided lanes are masked off port B, so each lane location has a single writer
  always_ff @(posedge clk) begin
`ifdef BANKED_DP_RAM_INIT_CLEAR_EN
    if (state == CLEAR) mem[clr_addr] <= '0;
`endif
    for (int i = 0; i < LANES; i++) begin
      if (a_we_eff[i])
        mem[a_addr][lane_lsb(i, DWIDTH) +: DWIDTH] <= a_d[lane_lsb(i, DWIDTH) +: DWIDTH];
      if (b_we_res[i])
        mem[b_addr][lane_lsb(i, DWIDTH) +: DWIDTH] <= b_d[lane_lsb(i, DWIDTH) +: DWIDTH];
    end
  end

  // Resolved same-cycle write data as seen from each port's read address
  always_comb begin
    a_byp_mask = '0;
    b_byp_mask = '0;
    a_byp_d    = '0;
    b_byp_d    = '0;
    for (int i = 0; i < LANES; i++) begin
      if (a_we_eff[i]) begin
        a_byp_mask[i] = 1'b1;
        a_byp_d[lane_lsb(i, DWIDTH) +: DWIDTH] = a_d[lane_lsb(i, DWIDTH) +: DWIDTH];
      end else if (b_we_res[i] && same_addr) begin
        a_byp_mask[i] = 1'b1;
        a_byp_d[lane_lsb(i, DWIDTH) +: DWIDTH] = b_d[lane_lsb(i, DWIDTH) +: DWIDTH];
      end
      if (b_we_res[i]) begin
        b_byp_mask[i] = 1'b1;
        b_byp_d[lane_lsb(i, DWIDTH) +: DWIDTH] = b_d[lane_lsb(i, DWIDTH) +: DWIDTH];
      end else if (a_we_eff[i] && same_addr) begin
        b_byp_mask[i] = 1'b1;
        b_byp_d[lane_lsb(i, DWIDTH) +: DWIDTH] = a_d[lane_lsb(i, DWIDTH) +: DWIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      coll_count <= '0;
    else if (collision && (coll_count != COLL_CNT_MAX))
      coll_count <= coll_count + 1'b1;
  end

  bdr_read_pipe #(
    .DWIDTH(DWIDTH), .LANES(LANES), .READ_LATENCY(READ_LATENCY), .WRITE_FIRST(WRITE_FIRST)
  ) u_pipe_a (
    .clk(clk), .resetn(resetn), .rd_en(a_rd_en && !busy), .arr_q(mem[a_addr]),
    .byp_mask(a_byp_mask), .byp_d(a_byp_d), .q(a_q), .q_valid(a_q_valid)
  );

  bdr_read_pipe #(
    .DWIDTH(DWIDTH), .LANES(LANES), .READ_LATENCY(READ_LATENCY), .WRITE_FIRST(WRITE_FIRST)
  ) u_pipe_b (
    .clk(clk), .resetn(resetn), .rd_en(b_rd_en && !busy), .arr_q(mem[b_addr]),
    .byp_mask(b_byp_mask), .byp_d(b_byp_d), .q(b_q), .q_valid(b_q_valid)
  );

endmodule
